multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the P5 datapath; replaces the single-cycle combinational controller.
- Sequences one instruction over FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU-operand-2, register-write-address and register-write-data mux selects, plus all PC/IR/GRF/DM write enables.
- Sits between the instruction register fields and the shared datapath; encodings come from macro.v.

Parameters:
- MEM_HANDSHAKE, 1, when 1 FETCH and MEM wait for mem_ready; when 0 mem_ready is ignored (treated as 1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- funct  input  6  IR[5:0].
- zero  input  1  ALU equality flag, valid in EXEC.
- mem_ready  input  1  IM/DM access complete.
- pc_we  output  1  PC write enable.
- npc_sel  output  2  0 PC+4, 1 branch, 2 jump (j/jal), 3 register (jr).
- ir_we  output  1  IR write enable.
- reg_we  output  1  GRF write enable.
- mem_we  output  1  DM write enable.
- alu_ctrl  output  2  0 ADD, 1 SUB, 2 OR, 3 LUI.
- ext_op  output  1  0 zero-extend, 1 sign-extend.
- alu_op2_sel  output  2  `MUX_ALUOP2_REGSEL / `MUX_ALUOP2_EXTSEL.
- reg_waddr_sel  output  2  `MUX_REGWADDR_RDSEL / RTSEL / LINKSEL.
- reg_wdata_sel  output  2  `MUX_REGWDATA_ALUSEL / MEMSEL / LINKSEL.
- illegal  output  1  one-cycle pulse when an unsupported instruction is decoded.
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - reset_n low at a rising edge sets state=FETCH, class=NOP, retired=0 and clears the illegal/instr_done registers.
  - While reset_n is low, all write enables (pc_we, ir_we, reg_we, mem_we) are forced to 0 combinationally.
  - All selects are 0 during reset.
  - Reset mid-instruction abandons it with no partial writes after that edge.
- Outputs are Moore: decoded from the state register plus the class register. The class is latched at the DECODE→next edge from opcode/funct.
- Classes and opcode/funct matches:
  - RTYPE: addu (funct 100001) / subu (funct 100011).
  - ORI: 001101.
  - LUI: 001111.
  - LW: 100011.
  - SW: 101011.
  - BEQ: 000100.
  - JAL: 000011.
  - JR: funct 001000.
  - NOP: opcode 0 with funct 0 (sll $0 form).
  - ILLEGAL: anything else.
- FETCH:
  - ir_we=1, pc_we=1, npc_sel=0.
  - Waits while MEM_HANDSHAKE && !mem_ready; during the wait all enables are 0.
  - Advances to DECODE when ready.
- DECODE: no writes. Next state:
  - JAL → WB.
  - NOP or ILLEGAL → FETCH; ILLEGAL also pulses illegal, and both pulse instr_done.
  - All other classes → EXEC.
- EXEC:
  - RTYPE: alu_op2_sel=REG, alu_ctrl ADD (addu) or SUB (subu); next state WB.
  - ORI: alu_op2_sel=EXT, ext_op=0, alu_ctrl=OR; next state WB.
  - LUI: alu_op2_sel=EXT, alu_ctrl=LUI; next state WB.
  - LW/SW: alu_op2_sel=EXT, ext_op=1, alu_ctrl=ADD; next state MEM.
  - BEQ: alu_op2_sel=REG, alu_ctrl=SUB; pc_we=zero, npc_sel=1; next state FETCH with instr_done.
  - JR: pc_we=1, npc_sel=3; next state FETCH with instr_done.
- MEM:
  - Waits on mem_ready (same rule as FETCH).
  - SW: mem_we=1 only in the ready cycle, then FETCH with instr_done.
  - LW: goes to WB.
- WB:
  - reg_we=1, always one cycle, then FETCH with instr_done.
  - RTYPE: waddr=RD, wdata=ALU.
  - ORI/LUI: waddr=RT, wdata=ALU.
  - LW: waddr=RT, wdata=MEM.
  - JAL: waddr=LINK, wdata=LINK, plus pc_we=1, npc_sel=2.
- The PC already holds PC+4 after FETCH, so the link value and the branch base both equal the PC register.
- Unused selects hold 0. mem_we is never asserted outside MEM.
- retired increments on every instr_done, including NOP and ILLEGAL, and wraps modulo 2^CNT_W.
- Latency in cycles, no-wait: RTYPE/ORI/LUI 4, LW 5, SW 4, BEQ/JR 3, JAL 3, NOP/ILLEGAL 2.
- Simultaneous reset and instr_done: reset wins, so retired stays 0.

Decomposition:
- macro.v: add state codes S_FETCH..S_WB (3-bit), class codes, NPC_* and ALU_* encodings, and opcode/funct constants. The existing `MUX_*` select macros are reused unchanged.
- One combinational sub-module, ctrl_decode, maps opcode/funct to class. The FSM, output decode and counter stay in multicycle_ctrl.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with mem_ready=1 → all enables 0, retired=0. On release, cycle 1 is FETCH with ir_we=pc_we=1.
- addu (op 0, funct 100001), mem_ready=1 → 4 cycles.
  - EXEC: alu_op2_sel=REG, alu_ctrl=0.
  - WB: reg_we=1, waddr_sel=RD, wdata_sel=ALU.
  - instr_done once; retired=1.
- lw with mem_ready low 2 cycles in MEM → 7 cycles total, mem_we never 1.
  - WB: waddr_sel=RT, wdata_sel=MEM.
  - sw under the same stall → mem_we=1 exactly once.
- beq with zero=1, then beq with zero=0 → EXEC pc_we is 1 then 0, npc_sel=1 in both; 3 cycles each.
- jal → F,D,WB: WB has reg_we=1, waddr_sel=LINK, wdata_sel=LINK, pc_we=1, npc_sel=2.
  - jr → EXEC has pc_we=1, npc_sel=3.
- Opcode 111111 → illegal pulses in DECODE, no reg/mem write, back to FETCH after 2 cycles, retired +1.
  - Assert reset_n=0 during the MEM stall of a sw → no mem_we; state is FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle P5 controller: FSM states, instruction
// classes, next-PC/ALU codes, datapath mux selects and opcode/funct constants.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LUI     = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } cls_e;

    // sub distinguishes subu from addu inside the RTYPE class
    typedef struct packed {
        cls_e cls;
        logic sub;
    } dec_t;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic [1:0] MUX_ALUOP2_REGSEL    = 2'd0;
    localparam logic [1:0] MUX_ALUOP2_EXTSEL    = 2'd1;
    localparam logic [1:0] MUX_REGWADDR_RDSEL   = 2'd0;
    localparam logic [1:0] MUX_REGWADDR_RTSEL   = 2'd1;
    localparam logic [1:0] MUX_REGWADDR_LINKSEL = 2'd2;
    localparam logic [1:0] MUX_REGWDATA_ALUSEL  = 2'd0;
    localparam logic [1:0] MUX_REGWDATA_MEMSEL  = 2'd1;
    localparam logic [1:0] MUX_REGWDATA_LINKSEL = 2'd2;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status in, enables and selects out.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             ir_we;
    logic             reg_we;
    logic             mem_we;
    logic [1:0]       alu_ctrl;
    logic             ext_op;
    logic [1:0]       alu_op2_sel;
    logic [1:0]       reg_waddr_sel;
    logic [1:0]       reg_wdata_sel;
    logic             illegal;
    logic             instr_done;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, npc_sel, ir_we, reg_we, mem_we, alu_ctrl, ext_op,
               alu_op2_sel, reg_waddr_sel, reg_wdata_sel, illegal, instr_done,
               retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, npc_sel, ir_we, reg_we, mem_we, alu_ctrl, ext_op,
               alu_op2_sel, reg_waddr_sel, reg_wdata_sel, illegal, instr_done,
               retired
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct to instruction-class decoder.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);
    always_comb begin
        dec_o.cls = CLS_ILLEGAL;
        dec_o.sub = 1'b0;
        case (opcode_i)
            OP_SPECIAL: begin
                case (funct_i)
                    FN_ADDU: dec_o.cls = CLS_RTYPE;
                    FN_SUBU: begin
                        dec_o.cls = CLS_RTYPE;
                        dec_o.sub = 1'b1;
                    end
                    FN_JR:   dec_o.cls = CLS_JR;
                    FN_SLL:  dec_o.cls = CLS_NOP;
                    default: dec_o.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  dec_o.cls = CLS_ORI;
            OP_LUI:  dec_o.cls = CLS_LUI;
            OP_LW:   dec_o.cls = CLS_LW;
            OP_SW:   dec_o.cls = CLS_SW;
            OP_BEQ:  dec_o.cls = CLS_BEQ;
            OP_JAL:  dec_o.cls = CLS_JAL;
            default: dec_o.cls = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle P5 control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore output
// decode from state + latched class, and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_ctrl_if.master    bus
);
    state_e           state_q, state_d;
    dec_t             cls_q, cls_d;
    dec_t             dec_now;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ready;

    logic       pc_we, ir_we, reg_we, mem_we, ext_op, illegal, instr_done;
    logic [1:0] npc_sel, alu_ctrl, alu_op2_sel, reg_waddr_sel, reg_wdata_sel;

    assign ready = !MEM_HANDSHAKE || bus.mem_ready;

    ctrl_decode u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .dec_o    (dec_now)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cls_q     <= '{cls: CLS_NOP, sub: 1'b0};
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_FETCH: if (ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d = dec_now;
                case (dec_now.cls)
                    CLS_JAL:              state_d = S_WB;
                    CLS_NOP, CLS_ILLEGAL: state_d = S_FETCH;
                    default:              state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q.cls)
                    CLS_LW, CLS_SW:   state_d = S_MEM;
                    CLS_BEQ, CLS_JR:  state_d = S_FETCH;
                    default:          state_d = S_WB;
                endcase
            end
            S_MEM: if (ready) state_d = (cls_q.cls == CLS_SW) ? S_FETCH : S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Whole decode is gated by reset_n so enables and selects read 0 during reset
    always_comb begin
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        reg_we        = 1'b0;
        mem_we        = 1'b0;
        ext_op        = 1'b0;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        npc_sel       = NPC_PC4;
        alu_ctrl      = ALU_ADD;
        alu_op2_sel   = MUX_ALUOP2_REGSEL;
        reg_waddr_sel = MUX_REGWADDR_RDSEL;
        reg_wdata_sel = MUX_REGWDATA_ALUSEL;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    ir_we = ready;
                    pc_we = ready;
                end
                S_DECODE: begin
                    illegal    = (dec_now.cls == CLS_ILLEGAL);
                    instr_done = (dec_now.cls == CLS_ILLEGAL) || (dec_now.cls == CLS_NOP);
                end
                S_EXEC: begin
                    case (cls_q.cls)
                        CLS_RTYPE: begin
                            alu_op2_sel = MUX_ALUOP2_REGSEL;
                            alu_ctrl    = cls_q.sub ? ALU_SUB : ALU_ADD;
                        end
                        CLS_ORI: begin
                            alu_op2_sel = MUX_ALUOP2_EXTSEL;
                            alu_ctrl    = ALU_OR;
                        end
                        CLS_LUI: begin
                            alu_op2_sel = MUX_ALUOP2_EXTSEL;
                            alu_ctrl    = ALU_LUI;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_op2_sel = MUX_ALUOP2_EXTSEL;
                            ext_op      = 1'b1;
                            alu_ctrl    = ALU_ADD;
                        end
                        CLS_BEQ: begin
                            alu_op2_sel = MUX_ALUOP2_REGSEL;
                            alu_ctrl    = ALU_SUB;
                            pc_we       = bus.zero;
                            npc_sel     = NPC_BRANCH;
                            instr_done  = 1'b1;
                        end
                        CLS_JR: begin
                            pc_we      = 1'b1;
                            npc_sel    = NPC_REG;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (ready && cls_q.cls == CLS_SW) begin
                        mem_we     = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    case (cls_q.cls)
                        CLS_RTYPE: begin
                            reg_waddr_sel = MUX_REGWADDR_RDSEL;
                            reg_wdata_sel = MUX_REGWDATA_ALUSEL;
                        end
                        CLS_ORI, CLS_LUI: begin
                            reg_waddr_sel = MUX_REGWADDR_RTSEL;
                            reg_wdata_sel = MUX_REGWDATA_ALUSEL;
                        end
                        CLS_LW: begin
                            reg_waddr_sel = MUX_REGWADDR_RTSEL;
                            reg_wdata_sel = MUX_REGWDATA_MEMSEL;
                        end
                        CLS_JAL: begin
                            reg_waddr_sel = MUX_REGWADDR_LINKSEL;
                            reg_wdata_sel = MUX_REGWDATA_LINKSEL;
                            pc_we         = 1'b1;
                            npc_sel       = NPC_JUMP;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;

    assign bus.pc_we         = pc_we;
    assign bus.npc_sel       = npc_sel;
    assign bus.ir_we         = ir_we;
    assign bus.reg_we        = reg_we;
    assign bus.mem_we        = mem_we;
    assign bus.alu_ctrl      = alu_ctrl;
    assign bus.ext_op        = ext_op;
    assign bus.alu_op2_sel   = alu_op2_sel;
    assign bus.reg_waddr_sel = reg_waddr_sel;
    assign bus.reg_wdata_sel = reg_wdata_sel;
    assign bus.illegal       = illegal;
    assign bus.instr_done    = instr_done;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected outputs are built
// from the instruction-level sequencing rules, with random stalls and operands.
module tb_multicycle_ctrl;
    localparam int unsigned CNT_W = 4;

    // Expected-output record, one per clock cycle
    typedef struct packed {
        logic       pc_we;
        logic [1:0] npc;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic [1:0] alu;
        logic       ext;
        logic [1:0] op2;
        logic [1:0] wa;
        logic [1:0] wd;
        logic       ill;
        logic       done;
    } ov_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_ILL = 10;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;
    int   memwe_seen = 0;
    int   memwe_exp = 0;
    ov_t  act;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign act = {bus.pc_we, bus.npc_sel, bus.ir_we, bus.reg_we, bus.mem_we,
                  bus.alu_ctrl, bus.ext_op, bus.alu_op2_sel, bus.reg_waddr_sel,
                  bus.reg_wdata_sel, bus.illegal, bus.instr_done};

    always @(posedge clk) if (bus.mem_we === 1'b1) memwe_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b100001) return K_ADDU;
            if (fn == 6'b100011) return K_SUBU;
            if (fn == 6'b001000) return K_JR;
            if (fn == 6'b000000) return K_NOP;
            return K_ILL;
        end
        case (op)
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    // One cycle: drive at negedge, sample 1 time unit later
    task automatic step(input string tag, input ov_t e, input logic rn, input logic mr,
                        input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(negedge clk);
        reset_n       = rn;
        bus.mem_ready = mr;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        #1;
        check(tag, 32'(act), 32'(e));
        check({tag, "_retired"}, 32'(bus.retired), 32'(exp_ret & ((1 << CNT_W) - 1)));
    endtask

    function automatic ov_t fetch_vec();
        ov_t e = '0;
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        return e;
    endfunction

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fs, input int ms);
        int  k = classify(op, fn);
        ov_t e;
        for (int i = 0; i < fs; i++)
            step({tag, "_fstall"}, '0, 1'b1, 1'b0, 6'($urandom), 6'($urandom), 1'($urandom));
        step({tag, "_fetch"}, fetch_vec(), 1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
        e = '0;
        e.ill  = (k == K_ILL);
        e.done = (k == K_ILL) || (k == K_NOP);
        step({tag, "_decode"}, e, 1'b1, 1'($urandom), op, fn, 1'($urandom));
        if (k == K_ILL || k == K_NOP) begin
            exp_ret++;
            return;
        end
        if (k == K_JAL) begin
            e = '0;
            e.reg_we = 1'b1; e.wa = 2'd2; e.wd = 2'd2;
            e.pc_we = 1'b1; e.npc = 2'd2; e.done = 1'b1;
            step({tag, "_wb"}, e, 1'b1, 1'($urandom), op, fn, 1'($urandom));
            exp_ret++;
            return;
        end
        e = '0;
        case (k)
            K_SUBU:       e.alu = 2'd1;
            K_ORI:        begin e.alu = 2'd2; e.op2 = 2'd1; end
            K_LUI:        begin e.alu = 2'd3; e.op2 = 2'd1; end
            K_LW, K_SW:   begin e.ext = 1'b1; e.op2 = 2'd1; end
            K_BEQ:        begin e.alu = 2'd1; e.pc_we = z; e.npc = 2'd1; e.done = 1'b1; end
            K_JR:         begin e.pc_we = 1'b1; e.npc = 2'd3; e.done = 1'b1; end
            default: ;
        endcase
        step({tag, "_exec"}, e, 1'b1, 1'($urandom), op, fn, z);
        if (k == K_BEQ || k == K_JR) begin
            exp_ret++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < ms; i++)
                step({tag, "_mstall"}, '0, 1'b1, 1'b0, op, fn, 1'($urandom));
            e = '0;
            if (k == K_SW) begin
                e.mem_we = 1'b1;
                e.done   = 1'b1;
                memwe_exp++;
            end
            step({tag, "_mem"}, e, 1'b1, 1'b1, op, fn, 1'($urandom));
            if (k == K_SW) begin
                exp_ret++;
                return;
            end
        end
        e = '0;
        e.reg_we = 1'b1;
        e.done   = 1'b1;
        e.wa     = (k == K_ADDU || k == K_SUBU) ? 2'd0 : 2'd1;
        e.wd     = (k == K_LW) ? 2'd1 : 2'd0;
        step({tag, "_wb"}, e, 1'b1, 1'($urandom), op, fn, 1'($urandom));
        exp_ret++;
    endtask

    logic [5:0] tbl_op [10] = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                                6'b101011, 6'b000100, 6'b000011, 6'b000000, 6'b000000};
    logic [5:0] tbl_fn [10] = '{6'b100001, 6'b100011, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'b001000, 6'b000000};

    initial begin
        ov_t e;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;

        for (int i = 0; i < 3; i++)
            step("reset", '0, 1'b0, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom));

        run_instr("addu",  6'b000000, 6'b100001, 1'b0, 0, 0);
        run_instr("subu",  6'b000000, 6'b100011, 1'b0, 0, 0);
        run_instr("ori",   6'b001101, 6'h15, 1'b0, 0, 0);
        run_instr("lui",   6'b001111, 6'h2a, 1'b1, 0, 0);
        run_instr("lw",    6'b100011, 6'h3f, 1'b0, 0, 2);
        run_instr("sw",    6'b101011, 6'h07, 1'b0, 0, 2);
        run_instr("beq_t", 6'b000100, 6'h01, 1'b1, 0, 0);
        run_instr("beq_f", 6'b000100, 6'h01, 1'b0, 0, 0);
        run_instr("jal",   6'b000011, 6'h11, 1'b0, 0, 0);
        run_instr("jr",    6'b000000, 6'b001000, 1'b0, 0, 0);
        run_instr("ill",   6'b111111, 6'h00, 1'b0, 0, 0);
        run_instr("nop",   6'b000000, 6'b000000, 1'b0, 0, 0);
        run_instr("addu_fs", 6'b000000, 6'b100001, 1'b0, 2, 0);

        // Reset on the final cycle of jr: reset wins, counter returns to 0
        step("jrrst_fetch", fetch_vec(), 1'b1, 1'b1, '0, '0, 1'b0);
        step("jrrst_decode", '0, 1'b1, 1'b1, 6'b000000, 6'b001000, 1'b0);
        step("jrrst_exec", '0, 1'b0, 1'b1, 6'b000000, 6'b001000, 1'b1);
        exp_ret = 0;
        run_instr("after_jrrst", 6'b001101, 6'h00, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int idx = $urandom_range(0, 10);
            logic [5:0] op, fn;
            if (idx == 10) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = tbl_op[idx];
                fn = tbl_fn[idx];
            end
            run_instr("rand", op, fn, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset during a stalled sw store: no write, back in FETCH
        step("swrst_fetch", fetch_vec(), 1'b1, 1'b1, '0, '0, 1'b0);
        step("swrst_decode", '0, 1'b1, 1'b1, 6'b101011, 6'h00, 1'b0);
        e = '0; e.ext = 1'b1; e.op2 = 2'd1;
        step("swrst_exec", e, 1'b1, 1'b1, 6'b101011, 6'h00, 1'b0);
        step("swrst_stall", '0, 1'b1, 1'b0, 6'b101011, 6'h00, 1'b0);
        step("swrst_rst", '0, 1'b0, 1'b1, 6'b101011, 6'h00, 1'b0);
        exp_ret = 0;
        run_instr("after_swrst", 6'b000000, 6'b100011, 1'b0, 0, 0);

        @(negedge clk);
        check("mem_we_count", 32'(memwe_seen), 32'(memwe_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
